acc_control_sequencer: RTL and testbench
========================================

Name: acc_control_sequencer

Overview:
Instruction sequencer for the 8-bit accumulator datapath. It fetches and decodes instructions and sequences the memory accesses for each one. It drives the one-hot ALU op pulses (AND, ADD, LDA, CMA, CIR, CIL) and the load strobes that the AC/DR registers and the adder/logic unit consume. It sits directly upstream of the adder/logic unit and owns PC, AR and IR.

Parameters:
AW, 8, memory address width (PC, AR, mem_addr)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin or resume execution (level, sampled in IDLE/HALT)
mem_rdata  in  8  memory read data
mem_ack  in  1  memory access complete this cycle
mem_addr  out  AW  memory address
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request (write data = AC, from datapath), held until mem_ack
dr_ld  out  1  DR <= mem_rdata at this edge
ac_ld  out  1  AC <= ALU ACData at this edge
AND, ADD, LDA, CMA, CIR, CIL  out  1 each  ALU op selects, one-hot, one-cycle pulses
pc  out  AW  program counter (debug)
ir  out  8  instruction register (debug)
halted  out  1  high in HALT state
ill_op  out  1  one-cycle pulse on reserved opcode

Behaviour:
- Reset: the reset is asynchronous, active-low, and forces these values: state = IDLE, pc = RESET_PC, AR = 0, ir = 0. All strobes, requests and op pulses = 0. mem_addr = 0, halted = 0. Reset mid-access drops mem_rd/mem_wr immediately, and the next access does not depend on the pending ack.
- Instruction byte 0 format: [7] = I (indirect), [6:4] = D (opcode), [3:0] = F (register function).
- D decode: 0 AND, 1 ADD, 2 LDA, 3 STA, 4 BUN, 5/6 reserved, 7 register-reference.
- Memory-reference (D = 0..4): byte 1 at PC+1 holds the address.
- F decode (D = 7): 1 CMA, 2 CIR, 3 CIL, F = HLT. All other F values are NOP.
- Memory handshake:
  - mem_rd/mem_wr and mem_addr stay stable from assertion until the cycle mem_ack = 1.
  - Read data is captured on that same clock edge.
  - mem_ack while neither request is asserted is ignored.
  - Zero-wait memory (mem_ack tied 1) is supported: each access takes 1 cycle.
- States:
  - IDLE: wait for start = 1, then go to FETCH0.
  - FETCH0: mem_rd at pc. On ack: ir <= mem_rdata, pc <= pc+1, go to DECODE.
  - DECODE: 1 cycle, no bus activity.
    - D = 7: go to EXEC_REG.
    - D = 5/6: pulse ill_op, go to FETCH0 (no operand fetch).
    - Otherwise: go to FETCH1.
  - FETCH1: mem_rd at pc. On ack: AR <= mem_rdata, pc <= pc+1.
    - I = 1: go to INDIRECT.
    - Otherwise: go to OPERAND (D = 0..2), STORE (D = 3) or BRANCH (D = 4).
  - INDIRECT: mem_rd at AR. On ack: AR <= mem_rdata, then same dispatch as FETCH1. One level of indirection only.
  - OPERAND: mem_rd at AR. On ack: dr_ld = 1 that cycle, go to EXEC_ALU.
  - EXEC_ALU: 1 cycle with ac_ld = 1 and exactly one of AND/ADD/LDA per D. Go to FETCH0.
  - STORE: mem_wr at AR. On ack: go to FETCH0.
  - BRANCH: 1 cycle, pc <= AR, go to FETCH0.
  - EXEC_REG: 1 cycle.
    - F = 1/2/3: CMA/CIR/CIL with ac_ld = 1, go to FETCH0.
    - F = F: go to HALT.
    - Other F: no pulses, go to FETCH0.
  - HALT: halted = 1. start = 1 goes to FETCH0 with pc unchanged.
- Op pulses and ac_ld are never asserted outside EXEC_ALU/EXEC_REG, and at most one op is high per cycle.
- start outside IDLE/HALT is ignored.
- PC and address arithmetic is modulo 2^AW: pc = 2^AW−1 increments to 0, and byte 1 of an instruction at the last address is read from address 0.
- Cycle counts with mem_ack = 1: AND/ADD/LDA 5 (+1 if I), STA 4 (+1), BUN 4 (+1), register-ref 3, reserved 2.

Test Plan:
- ADD direct: mem[0]=8'h10, mem[1]=8'h20, mem[0x20]=8'h05, mem_ack=1, start → dr_ld in cycle 4 with mem_addr=0x20; cycle 5 ADD=1, ac_ld=1; FETCH0 at pc=2 in cycle 6.
- LDA indirect: mem[0]=8'hA0, mem[1]=8'h30, mem[0x30]=8'h40 → read at 0x30 then operand read at 0x40; LDA pulse; 6 cycles total.
- Wait states: mem_ack low 3 cycles per access on STA 8'h30, 8'h50 → mem_wr held 4 cycles with mem_addr=0x50 stable; no op pulses during STA.
- Register-ref stream CMA (8'h71), CIR (8'h72), CIL (8'h73), NOP (8'h74), HLT (8'h7F) → one-cycle CMA, CIR, CIL pulses each with ac_ld; no pulse for 8'h74; halted=1 with pc=5; start resumes fetch at address 5.
- Edge cases: reserved 8'h50 → ill_op pulse, no FETCH1, next fetch at pc+1. BUN target 8'hFF followed by a 2-byte instruction → byte 1 fetched from address 0.
- Reset mid-access: rst_n=0 while mem_rd pending with mem_ack=0 → mem_rd=0, pc=RESET_PC, halted=0 immediately (asynchronous); IDLE until start.

Source files
------------

// File: rtl/acc_control_sequencer.sv
// Instruction sequencer for the 8-bit accumulator datapath.
// Owns PC/AR/IR, runs the memory handshake and emits ALU op pulses.
module acc_control_sequencer #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          dr_ld,
    output logic          ac_ld,
    output logic          AND,
    output logic          ADD,
    output logic          LDA,
    output logic          CMA,
    output logic          CIR,
    output logic          CIL,
    output logic [AW-1:0] pc,
    output logic [7:0]    ir,
    output logic          halted,
    output logic          ill_op
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH0,
        S_DECODE,
        S_FETCH1,
        S_INDIRECT,
        S_OPERAND,
        S_EXEC_ALU,
        S_STORE,
        S_BRANCH,
        S_EXEC_REG,
        S_HALT
    } state_t;

    // op vector bit order: {CIL, CIR, CMA, LDA, ADD, AND}
    localparam logic [5:0] OP_AND = 6'b000001;
    localparam logic [5:0] OP_ADD = 6'b000010;
    localparam logic [5:0] OP_LDA = 6'b000100;
    localparam logic [5:0] OP_CMA = 6'b001000;
    localparam logic [5:0] OP_CIR = 6'b010000;
    localparam logic [5:0] OP_CIL = 6'b100000;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ar_q, ar_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    ir_q, ir_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          ac_ld_q, ac_ld_d;
    logic          ill_q, ill_d;
    logic          halted_q, halted_d;
    logic [5:0]    op_q, op_d;

    // Memory-reference dispatch once the effective address is in AR
    function automatic state_t dispatch(input logic [2:0] d);
        state_t s;
        case (d)
            3'd0, 3'd1, 3'd2: s = S_OPERAND;
            3'd3:             s = S_STORE;
            default:          s = S_BRANCH;
        endcase
        return s;
    endfunction

    // Next state and PC/AR/IR updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ar_d    = ar_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH0;
            end
            S_FETCH0: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q[6:4] == 3'd7) begin
                    state_d = S_EXEC_REG;
                end else if (ir_q[6:4] == 3'd5 || ir_q[6:4] == 3'd6) begin
                    state_d = S_FETCH0;
                end else begin
                    state_d = S_FETCH1;
                end
            end
            S_FETCH1: begin
                if (mem_ack) begin
                    ar_d    = AW'(mem_rdata);
                    pc_d    = pc_q + AW'(1);
                    state_d = ir_q[7] ? S_INDIRECT : dispatch(ir_q[6:4]);
                end
            end
            S_INDIRECT: begin
                if (mem_ack) begin
                    ar_d    = AW'(mem_rdata);
                    state_d = dispatch(ir_q[6:4]);
                end
            end
            S_OPERAND: begin
                if (mem_ack) state_d = S_EXEC_ALU;
            end
            S_EXEC_ALU: begin
                state_d = S_FETCH0;
            end
            S_STORE: begin
                if (mem_ack) state_d = S_FETCH0;
            end
            S_BRANCH: begin
                pc_d    = ar_q;
                state_d = S_FETCH0;
            end
            S_EXEC_REG: begin
                state_d = (ir_q[3:0] == 4'hF) ? S_HALT : S_FETCH0;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so they come out of flops
    always_comb begin
        rd_d     = state_d inside {S_FETCH0, S_FETCH1, S_INDIRECT, S_OPERAND};
        wr_d     = (state_d == S_STORE);
        addr_d   = addr_q;
        op_d     = '0;
        ill_d    = (state_d == S_DECODE) &&
                   (ir_d[6:4] == 3'd5 || ir_d[6:4] == 3'd6);
        halted_d = (state_d == S_HALT);
        if (state_d inside {S_FETCH0, S_FETCH1}) begin
            addr_d = pc_d;
        end else if (state_d inside {S_INDIRECT, S_OPERAND, S_STORE}) begin
            addr_d = ar_d;
        end
        if (state_d == S_EXEC_ALU) begin
            case (ir_d[6:4])
                3'd0:    op_d = OP_AND;
                3'd1:    op_d = OP_ADD;
                3'd2:    op_d = OP_LDA;
                default: op_d = '0;
            endcase
        end else if (state_d == S_EXEC_REG) begin
            case (ir_d[3:0])
                4'h1:    op_d = OP_CMA;
                4'h2:    op_d = OP_CIR;
                4'h3:    op_d = OP_CIL;
                default: op_d = '0;
            endcase
        end
        ac_ld_d = |op_d;
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ar_q     <= '0;
            ir_q     <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ac_ld_q  <= 1'b0;
            op_q     <= '0;
            ill_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ac_ld_q  <= ac_ld_d;
            op_q     <= op_d;
            ill_q    <= ill_d;
            halted_q <= halted_d;
        end
    end

    // DR captures read data on the same edge the operand read completes
    assign dr_ld    = (state_q == S_OPERAND) && mem_ack;
    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign mem_wr   = wr_q;
    assign ac_ld    = ac_ld_q;
    assign AND      = op_q[0];
    assign ADD      = op_q[1];
    assign LDA      = op_q[2];
    assign CMA      = op_q[3];
    assign CIR      = op_q[4];
    assign CIL      = op_q[5];
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign halted   = halted_q;
    assign ill_op   = ill_q;

endmodule

// File: tb/tb_acc_control_sequencer.sv
// Bench for acc_control_sequencer: vector table with scoreboard,
// plus hand-written traces for timing, wait states, halt and reset.
module tb_acc_control_sequencer;

    localparam int AW = 8;

    localparam logic [5:0] P_AND = 6'b000001;
    localparam logic [5:0] P_ADD = 6'b000010;
    localparam logic [5:0] P_LDA = 6'b000100;
    localparam logic [5:0] P_CMA = 6'b001000;
    localparam logic [5:0] P_CIR = 6'b010000;
    localparam logic [5:0] P_CIL = 6'b100000;
    localparam logic [5:0] P_NONE = 6'b000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    mem_rdata;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, dr_ld, ac_ld;
    logic          AND, ADD, LDA, CMA, CIR, CIL;
    logic [AW-1:0] pc;
    logic [7:0]    ir;
    logic          halted, ill_op;

    logic [7:0] mem [256];
    int         nwait = 0;
    int         wcnt = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = 8'h00;
    int         n_chk = 0;
    int         n_pass = 0;

    typedef struct {
        logic [7:0] b0, b1, ptr;
        int         ncyc;
        logic [5:0] op;
        logic       ill;
        logic [7:0] nxt;
        int         nwr;
        logic [7:0] waddr;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       ill;
        int         nwr;
        logic [7:0] waddr;
    } exp_t;

    typedef struct {
        logic       rd, wr, dr, ac;
        logic [5:0] op;
        logic       ill;
        logic [7:0] addr;
    } cyc_t;

    vec_t vt[$];
    exp_t sb[$];
    cyc_t tr[$];

    acc_control_sequencer #(.AW(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dr_ld(dr_ld), .ac_ld(ac_ld),
        .AND(AND), .ADD(ADD), .LDA(LDA),
        .CMA(CMA), .CIR(CIR), .CIL(CIL),
        .pc(pc), .ir(ir), .halted(halted), .ill_op(ill_op)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, ack after nwait stall cycles
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (nwait == 0) ? 1'b1 : (wcnt == nwait);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if ((mem_rd || mem_wr) && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (rst_n && mem_wr && mem_ack) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [5:0] ops();
        return {CIL, CIR, CMA, LDA, ADD, AND};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        nwait = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    function automatic vec_t mkv(logic [7:0] b0, logic [7:0] b1,
                                 logic [7:0] ptr, int ncyc,
                                 logic [5:0] op, logic ill,
                                 logic [7:0] nxt, int nwr,
                                 logic [7:0] waddr);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.ptr = ptr; v.ncyc = ncyc;
        v.op = op; v.ill = ill; v.nxt = nxt;
        v.nwr = nwr; v.waddr = waddr;
        return v;
    endfunction

    function automatic cyc_t cy(logic rd, logic dr, logic ac,
                                logic [5:0] op, logic ill,
                                logic [7:0] a);
        cyc_t c;
        c.rd = rd; c.wr = 1'b0; c.dr = dr; c.ac = ac;
        c.op = op; c.ill = ill; c.addr = a;
        return c;
    endfunction

    // One instruction from reset with zero-wait memory
    task automatic run_vec(input int k, input vec_t v);
        exp_t e;
        logic [5:0] obs_op;
        int nop, nac, nill, bad, base;
        do_reset();
        clear_mem();
        mem[0] = v.b0;
        mem[1] = v.b1;
        mem[v.b1] = v.ptr;
        e.op = v.op; e.ill = v.ill; e.nwr = v.nwr; e.waddr = v.waddr;
        sb.push_back(e);
        obs_op = '0; nop = 0; nac = 0; nill = 0; bad = 0;
        base = wr_cnt;
        start = 1'b1;
        for (int c = 1; c <= v.ncyc + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= v.ncyc) begin
                obs_op |= ops();
                if (ops() != 0) nop++;
                if (ac_ld) nac++;
                if (ill_op) nill++;
                if (!$onehot0(ops()) || (ac_ld != (ops() != 0))) bad++;
            end
            if (c == v.ncyc + 1) begin
                check($sformatf("v%0d next_rd", k), mem_rd, 1);
                check($sformatf("v%0d next_addr", k), mem_addr, v.nxt);
            end
            if (c == v.ncyc + 2)
                check($sformatf("v%0d decode_rd", k), mem_rd, 0);
        end
        e = sb.pop_front();
        check($sformatf("v%0d op", k), obs_op, e.op);
        check($sformatf("v%0d op_cycles", k), nop, (e.op != 0) ? 1 : 0);
        check($sformatf("v%0d ac_cycles", k), nac, (e.op != 0) ? 1 : 0);
        check($sformatf("v%0d ill", k), nill, e.ill ? 1 : 0);
        check($sformatf("v%0d onehot", k), bad, 0);
        check($sformatf("v%0d writes", k), wr_cnt - base, e.nwr);
        if (e.nwr != 0)
            check($sformatf("v%0d wr_addr", k), wr_addr, e.waddr);
    endtask

    // Cycle-exact trace against the table in tr
    task automatic run_trace(input string nm);
        start = 1'b1;
        foreach (tr[i]) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s c%0d ctl", nm, i + 1),
                  {mem_rd, mem_wr, dr_ld, ac_ld, ops(), ill_op},
                  {tr[i].rd, tr[i].wr, tr[i].dr, tr[i].ac,
                   tr[i].op, tr[i].ill});
            if (tr[i].rd || tr[i].wr)
                check($sformatf("%s c%0d addr", nm, i + 1),
                      mem_addr, tr[i].addr);
        end
    endtask

    initial begin
        int c, nw, nrd, abad, nops, base;
        logic [5:0] seq[$];
        int nac;

        clear_mem();
        repeat (2) @(negedge clk);
        check("reset ctl",
              {mem_rd, mem_wr, dr_ld, ac_ld, ops(), ill_op, halted}, 0);
        check("reset addr", mem_addr, 0);
        check("reset pc", pc, 0);
        check("reset ir", ir, 0);
        rst_n = 1'b1;

        vt.push_back(mkv(8'h10, 8'h20, 8'h05, 5, P_ADD, 0, 8'h02, 0, 0));
        vt.push_back(mkv(8'h00, 8'h20, 8'h05, 5, P_AND, 0, 8'h02, 0, 0));
        vt.push_back(mkv(8'h20, 8'h20, 8'h05, 5, P_LDA, 0, 8'h02, 0, 0));
        vt.push_back(mkv(8'hA0, 8'h30, 8'h40, 6, P_LDA, 0, 8'h02, 0, 0));
        vt.push_back(mkv(8'h30, 8'h50, 8'h00, 4, P_NONE, 0, 8'h02, 1, 8'h50));
        vt.push_back(mkv(8'hB0, 8'h30, 8'h60, 5, P_NONE, 0, 8'h02, 1, 8'h60));
        vt.push_back(mkv(8'h40, 8'h80, 8'h00, 4, P_NONE, 0, 8'h80, 0, 0));
        vt.push_back(mkv(8'hC0, 8'h30, 8'h90, 5, P_NONE, 0, 8'h90, 0, 0));
        vt.push_back(mkv(8'h71, 8'h22, 8'h00, 3, P_CMA, 0, 8'h01, 0, 0));
        vt.push_back(mkv(8'h72, 8'h22, 8'h00, 3, P_CIR, 0, 8'h01, 0, 0));
        vt.push_back(mkv(8'h73, 8'h22, 8'h00, 3, P_CIL, 0, 8'h01, 0, 0));
        vt.push_back(mkv(8'h74, 8'h22, 8'h00, 3, P_NONE, 0, 8'h01, 0, 0));
        vt.push_back(mkv(8'h50, 8'h22, 8'h00, 2, P_NONE, 1, 8'h01, 0, 0));
        vt.push_back(mkv(8'h60, 8'h22, 8'h00, 2, P_NONE, 1, 8'h01, 0, 0));
        foreach (vt[i]) run_vec(i, vt[i]);

        // ADD direct, cycle by cycle
        do_reset();
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h20; mem[8'h20] = 8'h05;
        tr.delete();
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(0, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h01));
        tr.push_back(cy(1, 1, 0, P_NONE, 0, 8'h20));
        tr.push_back(cy(0, 0, 1, P_ADD, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h02));
        run_trace("add_direct");
        check("add_direct pc", pc, 8'h02);

        // LDA indirect
        do_reset();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h30; mem[8'h30] = 8'h40;
        tr.delete();
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(0, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h01));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h30));
        tr.push_back(cy(1, 1, 0, P_NONE, 0, 8'h40));
        tr.push_back(cy(0, 0, 1, P_LDA, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h02));
        run_trace("lda_ind");

        // Reserved opcode: no operand fetch
        do_reset();
        clear_mem();
        mem[0] = 8'h50;
        tr.delete();
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(0, 0, 0, P_NONE, 1, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h01));
        run_trace("reserved");

        // BUN to 0xFF, then ADD there takes byte 1 from address 0
        do_reset();
        clear_mem();
        mem[0] = 8'h40; mem[1] = 8'hFF; mem[8'hFF] = 8'h10;
        tr.delete();
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(0, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h01));
        tr.push_back(cy(0, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'hFF));
        tr.push_back(cy(0, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h00));
        tr.push_back(cy(1, 1, 0, P_NONE, 0, 8'h40));
        tr.push_back(cy(0, 0, 1, P_ADD, 0, 8'h00));
        tr.push_back(cy(1, 0, 0, P_NONE, 0, 8'h01));
        run_trace("bun_wrap");

        // STA with three wait states per access
        do_reset();
        clear_mem();
        mem[0] = 8'h30; mem[1] = 8'h50;
        nwait = 3;
        base = wr_cnt;
        nw = 0; nrd = 0; abad = 0; nops = 0; c = 0;
        start = 1'b1;
        while (c < 60 && !(nw > 0 && !mem_wr)) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (mem_wr) begin
                nw++;
                if (mem_addr != 8'h50) abad++;
            end
            if (mem_rd && nw == 0) nrd++;
            if (ops() != 0 || ac_ld) nops++;
        end
        check("sta_wait wr_cycles", nw, 4);
        check("sta_wait rd_cycles", nrd, 8);
        check("sta_wait addr_stable", abad, 0);
        check("sta_wait no_ops", nops, 0);
        check("sta_wait writes", wr_cnt - base, 1);
        check("sta_wait end_cycle", c, 14);
        check("sta_wait next_fetch", {mem_rd, mem_addr}, {1'b1, 8'h02});

        // Register-reference stream ending in HLT, then resume
        do_reset();
        clear_mem();
        mem[0] = 8'h71; mem[1] = 8'h72; mem[2] = 8'h73;
        mem[3] = 8'h74; mem[4] = 8'h7F; mem[5] = 8'h74;
        seq.delete();
        nac = 0; c = 0;
        start = 1'b1;
        while (!halted && c < 40) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (ops() != 0) seq.push_back(ops());
            if (ac_ld) nac++;
        end
        check("regs halted", halted, 1);
        check("regs halt_cycle", c, 16);
        check("regs pulses", seq.size(), 3);
        check("regs p0", (seq.size() > 0) ? seq[0] : 6'h0, P_CMA);
        check("regs p1", (seq.size() > 1) ? seq[1] : 6'h0, P_CIR);
        check("regs p2", (seq.size() > 2) ? seq[2] : 6'h0, P_CIL);
        check("regs ac_ld", nac, 3);
        check("regs pc", pc, 8'h05);
        repeat (2) @(negedge clk);
        check("regs stays_halted", {halted, mem_rd}, 2'b10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("regs resume",
              {halted, mem_rd, mem_addr}, {1'b0, 1'b1, 8'h05});

        // Asynchronous reset while a read is stalled
        do_reset();
        clear_mem();
        mem[0] = 8'h71;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        nwait = 200;
        repeat (3) @(negedge clk);
        check("rst_mid pending", {mem_rd, mem_addr}, {1'b1, 8'h01});
        check("rst_mid pc_before", pc, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid rd", mem_rd, 0);
        check("rst_mid pc", pc, 8'h00);
        check("rst_mid halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nwait = 0;
        nrd = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd || mem_wr) nrd++;
        end
        check("rst_mid idle", nrd, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid restart", {mem_rd, mem_addr}, {1'b1, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
